// File: rtl/xmega_regs_wport.sv
// Write-port sequencer for the xmega register file: zero-fill after reset, then
// fixed-priority sharing of the single write port between ALU, load FIFO and debug.
module xmega_regs_wport #(
    parameter string CLEAR_ON_RESET = "TRUE",
    parameter int    LD_DEPTH       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alu_a,
    input  logic [15:0] alu_d,
    input  logic        alu_w,
    input  logic        alu_m,
    input  logic [4:0]  ld_a,
    input  logic [7:0]  ld_d,
    input  logic        ld_v,
    output logic        ld_full,
    output logic        ld_ovf,
    input  logic [4:0]  dbg_a,
    input  logic [7:0]  dbg_d,
    input  logic        dbg_req,
    output logic        dbg_ack,
    input  logic [4:0]  chk_a,
    output logic        chk_hit,
    output logic        busy,
    output logic [4:0]  rda,
    output logic [15:0] rd,
    output logic        rdw,
    output logic        rdm
);
    localparam bit DO_CLEAR = (CLEAR_ON_RESET == "TRUE");
    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    fa_q [LD_DEPTH];
    logic [4:0]    fa_d [LD_DEPTH];
    logic [7:0]    fd_q [LD_DEPTH];
    logic [7:0]    fd_d [LD_DEPTH];
    logic          ld_ovf_q, ld_ovf_d, ld_full_q, ld_full_d;
    logic          push, pop;
    logic [PW-1:0] idx;

    always_comb begin
        rda     = '0;
        rd      = '0;
        rdm     = 1'b0;
        rdw     = 1'b0;
        dbg_ack = 1'b0;
        pop     = 1'b0;
        if (!rst) begin
            if (state_q == CLEAR) begin
                rdw = 1'b1;
                rdm = 1'b1;
                rda = {1'b0, cnt_q};
            end else if (alu_w) begin
                rdw = 1'b1;
                rdm = alu_m;
                rda = alu_a;
                rd  = alu_d;
            end else if (count_q != '0) begin
                pop = 1'b1;
                rdw = 1'b1;
                rda = fa_q[rd_ptr_q];
                rd  = {8'h00, fd_q[rd_ptr_q]};
            end else if (dbg_req) begin
                rdw     = 1'b1;
                dbg_ack = 1'b1;
                rda     = dbg_a;
                rd      = {8'h00, dbg_d};
            end
        end
    end

    // Space is judged on the registered count, so a same-cycle pop never makes room.
    always_comb begin
        push     = ld_v && (state_q == RUN) && (count_q < DEPTH_C);
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fa_d     = fa_q;
        fd_d     = fd_q;
        ld_ovf_d = ld_ovf_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'hF) state_d = RUN;
        end
        if (push) begin
            fa_d[wr_ptr_q] = ld_a;
            fd_d[wr_ptr_q] = ld_d;
            wr_ptr_d       = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ld_v && !push) ld_ovf_d = 1'b1;
        ld_full_d = (state_d == CLEAR) || (count_d == DEPTH_C);
    end

    always_comb begin
        chk_hit = 1'b0;
        idx     = '0;
        for (int k = 0; k < LD_DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (fa_q[idx] == chk_a)) chk_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DO_CLEAR ? CLEAR : RUN;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ld_ovf_q  <= 1'b0;
            ld_full_q <= DO_CLEAR;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ld_ovf_q  <= ld_ovf_d;
            ld_full_q <= ld_full_d;
        end
    end

    always_ff @(posedge clk) begin
        fa_q <= fa_d;
        fd_q <= fd_d;
    end

    assign ld_full = rst | ld_full_q;
    assign ld_ovf  = ld_ovf_q;
    assign busy    = rst ? DO_CLEAR : (state_q == CLEAR);
endmodule

// File: tb/tb_xmega_regs_wport.sv
// Self-checking bench for xmega_regs_wport: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_xmega_regs_wport;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alu_a, ld_a, dbg_a, chk_a;
    logic [15:0] alu_d;
    logic [7:0]  ld_d, dbg_d;
    logic        alu_w, alu_m, ld_v, dbg_req;
    logic        ld_full, ld_ovf, dbg_ack, chk_hit, busy, rdw, rdm;
    logic [4:0]  rda;
    logic [15:0] rd;
    logic        n_ld_full, n_ld_ovf, n_dbg_ack, n_chk_hit, n_busy, n_rdw, n_rdm;
    logic [4:0]  n_rda;
    logic [15:0] n_rd;

    int checks = 0;
    int errors = 0;

    logic [12:0] mq[$];
    bit          m_clear = 1'b1;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    bit          m_full = 1'b1;
    bit          noclr_idle = 1'b0;

    always #5 clk = ~clk;

    xmega_regs_wport #(.CLEAR_ON_RESET("TRUE"), .LD_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .alu_a(alu_a), .alu_d(alu_d), .alu_w(alu_w), .alu_m(alu_m),
        .ld_a(ld_a), .ld_d(ld_d), .ld_v(ld_v), .ld_full(ld_full), .ld_ovf(ld_ovf),
        .dbg_a(dbg_a), .dbg_d(dbg_d), .dbg_req(dbg_req), .dbg_ack(dbg_ack),
        .chk_a(chk_a), .chk_hit(chk_hit), .busy(busy),
        .rda(rda), .rd(rd), .rdw(rdw), .rdm(rdm)
    );

    xmega_regs_wport #(.CLEAR_ON_RESET("NONE"), .LD_DEPTH(2)) u_noclr (
        .clk(clk), .rst(rst), .alu_a(alu_a), .alu_d(alu_d), .alu_w(alu_w), .alu_m(alu_m),
        .ld_a(ld_a), .ld_d(ld_d), .ld_v(ld_v), .ld_full(n_ld_full), .ld_ovf(n_ld_ovf),
        .dbg_a(dbg_a), .dbg_d(dbg_d), .dbg_req(dbg_req), .dbg_ack(n_dbg_ack),
        .chk_a(chk_a), .chk_hit(n_chk_hit), .busy(n_busy),
        .rda(n_rda), .rd(n_rd), .rdw(n_rdw), .rdm(n_rdm)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; alu_w = 1'b0; alu_m = 1'b0; alu_a = '0; alu_d = '0;
        ld_v = 1'b0; ld_a = '0; ld_d = '0;
        dbg_req = 1'b0; dbg_a = '0; dbg_d = '0; chk_a = '0;
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic checkOutput();
        logic [4:0]  e_rda;
        logic [15:0] e_rd;
        logic        e_rdw, e_rdm, e_ack, e_busy, e_full, e_hit;
        bit          e_pop;
        int          sz;
        #1;
        e_rda = '0; e_rd = '0; e_rdw = 0; e_rdm = 0; e_ack = 0; e_busy = 0; e_full = 0; e_pop = 0;
        if (rst) begin
            e_busy = 1; e_full = 1;
        end else if (m_clear) begin
            e_rdw = 1; e_rdm = 1; e_rda = 5'(m_cnt); e_busy = 1; e_full = 1;
        end else begin
            e_full = m_full;
            if (alu_w) begin
                e_rdw = 1; e_rdm = alu_m; e_rda = alu_a; e_rd = alu_d;
            end else if (mq.size() > 0) begin
                e_pop = 1; e_rdw = 1; e_rda = mq[0][12:8]; e_rd = {8'h00, mq[0][7:0]};
            end else if (dbg_req) begin
                e_rdw = 1; e_ack = 1; e_rda = dbg_a; e_rd = {8'h00, dbg_d};
            end
        end
        e_hit = 0;
        foreach (mq[i]) if (mq[i][12:8] == chk_a) e_hit = 1;
        chk("rdw", rdw, e_rdw);
        chk("rda", rda, e_rda);
        chk("rd", rd, e_rd);
        chk("rdm", rdm, e_rdm);
        chk("dbg_ack", dbg_ack, e_ack);
        chk("busy", busy, e_busy);
        chk("ld_full", ld_full, e_full);
        chk("ld_ovf", ld_ovf, m_ovf);
        chk("chk_hit", chk_hit, e_hit);
        chk("noclr_busy", n_busy, 1'b0);
        if (noclr_idle) begin
            chk("noclr_rdw", n_rdw, 1'b0);
            chk("noclr_full", n_ld_full, 1'b0);
        end
        @(posedge clk);
        if (rst) begin
            m_clear = 1; m_cnt = 0; mq.delete(); m_ovf = 0; m_full = 1;
        end else begin
            sz = mq.size();
            if (e_pop) void'(mq.pop_front());
            if (ld_v) begin
                if (!m_clear && sz < 2) mq.push_back({ld_a, ld_d});
                else m_ovf = 1;
            end
            if (m_clear) begin
                m_cnt++;
                if (m_cnt == 16) m_clear = 0;
            end
            m_full = m_clear || (mq.size() == 2);
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            alu_w   = ($urandom_range(0, 1) == 1);
            alu_m   = 1'($urandom);
            alu_a   = 5'($urandom);
            alu_d   = 16'($urandom);
            ld_v    = ($urandom_range(0, 9) < 4);
            ld_a    = 5'($urandom_range(0, 7));
            ld_d    = 8'($urandom);
            if (!dbg_req || dbg_ack) dbg_req = ($urandom_range(0, 3) == 0);
            dbg_a   = 5'($urandom);
            dbg_d   = 8'($urandom);
            chk_a   = 5'($urandom_range(0, 7));
            checkOutput();
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput();

        // Zero-fill interrupted at cnt=7, then a complete fill with ALU/debug ignored.
        rst = 1'b0; noclr_idle = 1'b1;
        checkOutput();
        noclr_idle = 1'b0;
        repeat (6) checkOutput();
        rst = 1'b1;
        checkOutput();
        rst = 1'b0; alu_w = 1'b1; alu_a = 5'd3; alu_d = 16'hBEEF; dbg_req = 1'b1;
        repeat (16) checkOutput();
        idle();
        checkOutput();

        // Priority: ALU, then two loads in push order, then debug.
        alu_w = 1'b1; alu_a = 5'd9; alu_d = 16'h1234;
        ld_v = 1'b1; ld_a = 5'd3; ld_d = 8'h11;
        checkOutput();
        ld_a = 5'd4; ld_d = 8'h22;
        checkOutput();
        ld_v = 1'b0; alu_a = 5'd5; alu_d = 16'h00AA;
        dbg_req = 1'b1; dbg_a = 5'd30; dbg_d = 8'h5A;
        checkOutput();
        alu_w = 1'b0;
        repeat (3) checkOutput();
        idle();
        checkOutput();

        // Overflow while ALU holds the port.
        alu_w = 1'b1; alu_m = 1'b1; alu_a = 5'd2; alu_d = 16'hC0DE; ld_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_a = 5'(6 + i); ld_d = 8'(8'h40 + i);
            checkOutput();
        end
        idle();
        repeat (3) checkOutput();

        // Alternating push/pop across pointer wrap.
        for (int i = 1; i <= 10; i++) begin
            ld_v = 1'b1; ld_a = 5'(i); ld_d = 8'(i * 3);
            checkOutput();
            ld_v = 1'b0;
            checkOutput();
        end

        // Hazard probe on r17, then a non-matching probe.
        for (int p = 0; p < 2; p++) begin
            chk_a = (p == 0) ? 5'd17 : 5'd16;
            ld_v = 1'b1; ld_a = 5'd17; ld_d = 8'h77;
            checkOutput();
            ld_v = 1'b0; alu_w = 1'b1;
            repeat (2) checkOutput();
            alu_w = 1'b0;
            repeat (2) checkOutput();
        end
        idle();

        applyStimulus(400);
        idle();
        repeat (20) checkOutput();

        // Reset with two loads pending: nothing stale may drain afterwards.
        alu_w = 1'b1; ld_v = 1'b1; ld_a = 5'd12; ld_d = 8'h99;
        repeat (2) checkOutput();
        rst = 1'b1; ld_v = 1'b0;
        checkOutput();
        idle();
        repeat (20) checkOutput();

        // A push during zero-fill is dropped and flagged.
        rst = 1'b1;
        checkOutput();
        rst = 1'b0; ld_v = 1'b1; ld_a = 5'd1; ld_d = 8'h01;
        checkOutput();
        idle();
        repeat (17) checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xmega_regs_wport.md
# xmega_regs_wport

Write-port sequencer and arbiter for the xmega core register file. It shares the register file's single write port among three sources: ALU writeback, load/POP byte writeback, and the debug byte-write port. It also zero-fills all 32 registers after reset. It sits between the core pipeline and the register file and drives that file's `rda`/`rd`/`rdw`/`rdm` inputs directly.

## Interface
Parameters:
- `CLEAR_ON_RESET`, default "TRUE"
  - "TRUE": run the 16-cycle zero-fill after reset.
  - Any other value: go straight to RUN.
- `LD_DEPTH`, default 2: load FIFO depth. Legal values are 2 and 4.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `alu_a`  in  5  ALU destination. Byte address, or pair index in `alu_a[3:0]` when `alu_m`=1.
- `alu_d`  in  16  ALU write data; byte writes use `[7:0]`.
- `alu_w`  in  1  ALU write strobe.
- `alu_m`  in  1  ALU word (register pair) write.
- `ld_a`  in  5  load destination byte address.
- `ld_d`  in  8  load data byte.
- `ld_v`  in  1  load push strobe.
- `ld_full`  out  1  load FIFO cannot accept a push.
- `ld_ovf`  out  1  sticky: a push arrived while `ld_full`=1.
- `dbg_a`  in  5  debug destination byte address.
- `dbg_d`  in  8  debug data byte.
- `dbg_req`  in  1  debug write request, level; held until acknowledged.
- `dbg_ack`  out  1  one-cycle pulse in the cycle the debug write is issued.
- `chk_a`  in  5  byte address probed for pending loads.
- `chk_hit`  out  1  some valid FIFO entry targets `chk_a`.
- `busy`  out  1  zero-fill in progress; the core must stall.
- `rda`  out  5  register file write address.
- `rd`  out  16  register file write data.
- `rdw`  out  1  register file write enable.
- `rdm`  out  1  register file word mode.

## Operation
- States: CLEAR and RUN.
- Reset:
  - Next state is CLEAR if `CLEAR_ON_RESET`="TRUE", otherwise RUN.
  - Clear counter = 0, FIFO count = 0, FIFO pointers = 0, `ld_ovf` = 0.
- CLEAR:
  - Each cycle drive `rdw`=1, `rdm`=1, `rda`={1'b0,cnt[3:0]}, `rd`=16'h0000.
  - Increment `cnt`. After `cnt`=15 is issued, go to RUN.
  - `alu_w` and `dbg_req` are ignored. `dbg_ack`=0 and `ld_full`=1.
  - A push while in CLEAR sets `ld_ovf`.
- RUN uses fixed priority, one grant per cycle:
  1. `alu_w`=1: forward `alu_a`/`alu_d`/`alu_m` unchanged to `rda`/`rd`/`rdm`; `rdw`=1.
  2. Else if the FIFO is non-empty: pop the head and drive `rda`=head.a, `rd`={8'h00,head.d}, `rdm`=0, `rdw`=1.
  3. Else if `dbg_req`=1: drive `rda`=`dbg_a`, `rd`={8'h00,`dbg_d`}, `rdm`=0, `rdw`=1, `dbg_ack`=1.
  4. Else `rdw`=0. `rda`, `rd` and `rdm` are then 0.
- Load FIFO:
  - In-order circular buffer of {a[4:0], d[7:0]}.
  - A push is accepted when `ld_v`=1 and count<`LD_DEPTH`.
  - `ld_full` is registered: it equals (count==`LD_DEPTH`), or 1 in CLEAR.
  - A push while full is dropped and sets `ld_ovf`. A same-cycle pop does not free space for that push.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo `LD_DEPTH`.
- `chk_hit` is combinational: OR over valid entries of (entry.a==`chk_a`). An entry popped in the current cycle still counts.
- Ordering:
  - Loads are never reordered among themselves.
  - Ordering between sources is the core's job. The core uses `chk_hit` to hold back an ALU write or read that collides with a pending load.
- Debug may starve while ALU or load traffic continues. This is accepted because debug writes only occur with the core halted.

## Timing
- `rda`/`rd`/`rdw`/`rdm`/`dbg_ack` are combinational from the current state and inputs. The register file captures the write at the next rising edge.
- Write latency: ALU 0 cycles; load ≥1 cycle after push (no bypass); debug 0 cycles when idle.
- Zero-fill: with `rst` high at edge E0, CLEAR writes issue in the 16 cycles after E0.
  - `busy`=1 from E0 through the 16th write cycle.
  - `busy`=0 starting at the edge that ends the 16th write.
- While `rst`=1: `rdw`=0, `dbg_ack`=0, `busy`=1 if `CLEAR_ON_RESET`="TRUE" else 0, `ld_full`=1.
- Reset mid-CLEAR restarts the counter from 0.
- Reset mid-RUN flushes the FIFO; pending loads are lost.
- `ld_ovf` clears only on reset.

## Test plan
- Zero-fill: release `rst` with `CLEAR_ON_RESET`="TRUE" → 16 word writes to pairs 0..15 with data 0000, then `busy` falls; with any other value → `busy`=0 and no writes.
- Priority: `alu_w`=1 (a=5, d=00AA), 2 loads queued, and `dbg_req`=1 together → cycle 0 ALU write, cycles 1-2 loads in push order, cycle 3 debug with `dbg_ack`=1 for exactly that cycle.
- FIFO full/overflow (`LD_DEPTH`=2): hold `alu_w`=1 and push 3 loads → `ld_full`=1 after the 2nd push; the 3rd is dropped and `ld_ovf`=1; the 2 stored loads drain in order once `alu_w`=0.
- Wrap-around: 10 alternating push/pop cycles to addresses 1..10 → writes appear in order with correct data; count never exceeds 1.
- Hazard probe: push load to r17 with `chk_a`=17 → `chk_hit`=1 until the cycle the entry is popped, then 0; `chk_a`=16 → 0 throughout.
- Reset mid-op: assert `rst` during CLEAR at `cnt`=7 and again with 2 loads queued → clear restarts at pair 0, FIFO is empty, `ld_ovf`=0, and no stale load writes appear.
